uart_bus_responder: RTL and testbench
=====================================

Name: uart_bus_responder

Overview:
- Device-side model of the board UART chip: it answers the host memory/UART controller on the rdn/wrn strobe bus.
- Serialises bytes the host writes onto txd, and deserialises rxd into a small receive FIFO that the host reads.
- Drives the data_ready/tbre/tsre status lines the controller polls.
- Used as a synthesizable loopback/peer in FPGA bring-up and as the bus responder in system simulation. Shares clk with the controller.

Parameters:
- CLK_DIV, 16, clk cycles per serial bit (even, >=4)
- FIFO_AW, 2, receive FIFO address width (depth 2^FIFO_AW = 4)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- rdn  in  1  host read strobe, active-low
- wrn  in  1  host write strobe, active-low
- data_in  in  8  bus value driven by host (low byte of data bus)
- data_out  out  8  byte presented to bus on read
- data_oe  out  1  tri-state enable for data_out (top level drives the bus when 1)
- data_ready  out  1  receive FIFO non-empty
- tbre  out  1  transmit holding register empty
- tsre  out  1  transmit shift register empty (line idle)
- rxd  in  1  serial input, idle high, asynchronous
- txd  out  1  serial output, idle high
- rx_overrun  out  1  sticky: byte dropped because FIFO full
- frame_err  out  1  one-cycle pulse: received stop bit was 0

Behaviour:
- Reset values:
  - txd=1, tbre=1, tsre=1, data_ready=0, rx_overrun=0, frame_err=0, data_out=0.
  - FIFO empty; both FSMs IDLE.
  - Reset mid-frame aborts the frame immediately; txd returns to 1.
- Strobe detect:
  - rdn_q/wrn_q are registered copies of rdn/wrn; reset value 1.
  - Edges are detected against these copies. rdn/wrn are synchronous to clk and need no synchroniser.
- Read path:
  - data_oe = ~rdn (combinational).
  - data_out = FIFO head (combinational). Shows 8'h00 when empty.
  - Pop on rdn rising edge (rdn_q=0, rdn=1) when non-empty. Rising edge while empty: no pop, no state change.
  - data_ready = (count!=0), registered. Updates the cycle after a push or pop.
- Write path:
  - While wrn=0, wr_byte <= data_in every cycle.
  - On wrn rising edge, THR <= wr_byte and tbre <= 0.
  - Write while tbre=0 overwrites THR (last write wins); no flag is raised.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when tbre=0, load shifter from THR, set tbre=1 and tsre=0, go to START. Load takes 1 cycle after the THR write.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; 3-bit bit counter.
  - STOP: txd=1 for CLK_DIV cycles. Then: if tbre=0, reload from THR back-to-back; otherwise tsre=1 and go to IDLE.
  - A frame is 10*CLK_DIV cycles from the START entry.
- RX FSM (IDLE, START, DATA, STOP):
  - rxd passes through a 2-flop synchroniser, reset value 1.
  - IDLE: on synced rxd=0, go to START with counter cleared.
  - START: at CLK_DIV/2, re-sample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every CLK_DIV cycles, 8 bits LSB first.
  - STOP: sample after CLK_DIV. If 1, push the byte. If 0, pulse frame_err for 1 cycle, discard the byte, and go to IDLE.
- FIFO:
  - Circular buffer; pointers wrap modulo 2^FIFO_AW; count is FIFO_AW+1 bits.
  - Push while full: byte dropped, rx_overrun set (cleared only by reset).
  - Push and pop in the same cycle: both performed, count unchanged. If full, the push is accepted because the pop frees the slot.
  - Pop and push in the same cycle on an empty FIFO: pop ignored, push performed.

Test Plan:
- CLK_DIV=4: host strobes wrn low for 2 cycles with data_in=8'hA5, then high -> tbre=0 for 1 cycle, then tsre=0; txd=0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tsre=1 after 40 cycles.
- Write 8'h12 then 8'h34 while first frame in START -> two back-to-back frames 12,34; no idle gap; tbre=1 after second load.
- Drive rxd frame 8'h3C at CLK_DIV=4 -> data_ready=1 one cycle after stop sample. rdn low gives data_oe=1, data_out=8'h3C. rdn rising edge -> data_ready=0.
- Send 5 bytes 01..05 without reading (depth 4) -> rx_overrun=1; reads return 01,02,03,04; then data_ready=0.
- rxd low pulse of 1 cycle -> no push, no frame_err. Frame with stop bit 0 -> frame_err pulse, FIFO unchanged.
- Assert rst mid-TX frame and mid-RX frame -> txd=1, tbre=tsre=1, data_ready=0 asynchronously; next frames work normally.

Source files
------------

// File: rtl/uart_bus_responder_if.sv
// Host-side strobe bus of the board UART chip: read/write strobes, data byte and
// the status lines the controller polls.
interface uart_bus_responder_if;
   logic       rdn;
   logic       wrn;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_oe;
   logic       data_ready;
   logic       tbre;
   logic       tsre;

   modport master (
      output rdn, wrn, data_in,
      input  data_out, data_oe, data_ready, tbre, tsre
   );

   modport slave (
      input  rdn, wrn, data_in,
      output data_out, data_oe, data_ready, tbre, tsre
   );
endinterface

// File: rtl/uart_bus_responder.sv
// Device-side model of the board UART: answers the host strobe bus, serialises
// written bytes onto txd and collects rxd frames into a small receive FIFO.
module uart_bus_responder #(
   parameter int CLK_DIV = 16,
   parameter int FIFO_AW = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_bus_responder_if.slave  bus,
   input  logic                 rxd,
   output logic                 txd,
   output logic                 rx_overrun,
   output logic                 frame_err
);

   localparam int DW    = $clog2(CLK_DIV);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [DW-1:0]      DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0]      HALF_LAST = DW'(CLK_DIV / 2 - 1);
   localparam logic [DW-1:0]      DIV_ONE   = DW'(1);
   localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   logic rdn_q, rdn_d, wrn_q, wrn_d;
   logic rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
   logic [7:0] wr_byte_q, wr_byte_d, thr_q, thr_d;
   logic tbre_q, tbre_d, tsre_q, tsre_d;
   tx_state_e tx_state_q, tx_state_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [DW-1:0] tx_div_q, tx_div_d;
   logic [2:0] tx_bit_q, tx_bit_d;

   rx_state_e rx_state_q, rx_state_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [DW-1:0] rx_div_q, rx_div_d;
   logic [2:0] rx_bit_q, rx_bit_d;
   logic frame_err_q, frame_err_d, rx_overrun_q, rx_overrun_d;

   logic [7:0] mem_q [DEPTH];
   logic [7:0] mem_d [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0] count_q, count_d;
   logic data_ready_q, data_ready_d;

   logic wr_rise, rd_rise, fifo_empty, fifo_full, push_req, push, pop;

   assign wr_rise    = ~wrn_q & bus.wrn;
   assign rd_rise    = ~rdn_q & bus.rdn;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_FULL);
   assign pop        = rd_rise & ~fifo_empty;
   // A full FIFO still accepts a push when the same cycle pops a slot free.
   assign push       = push_req & (~fifo_full | pop);

   assign bus.data_oe    = ~bus.rdn;
   assign bus.data_out   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
   assign bus.data_ready = data_ready_q;
   assign bus.tbre       = tbre_q;
   assign bus.tsre       = tsre_q;
   assign rx_overrun     = rx_overrun_q;
   assign frame_err      = frame_err_q;

   always_comb begin
      txd = 1'b1;
      if (tx_state_q == TX_START)     txd = 1'b0;
      else if (tx_state_q == TX_DATA) txd = tx_shift_q[0];
   end

   always_comb begin
      rdn_d     = bus.rdn;
      wrn_d     = bus.wrn;
      rx_s1_d   = rxd;
      rx_s2_d   = rx_s1_q;
      wr_byte_d = bus.wrn ? wr_byte_q : bus.data_in;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      thr_d      = thr_q;
      tbre_d     = tbre_q;
      tsre_d     = tsre_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (!tbre_q) begin
               tx_shift_d = thr_q;
               tbre_d     = 1'b1;
               tsre_d     = 1'b0;
               tx_div_d   = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_div_q == DIV_LAST) begin
               tx_div_d   = '0;
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end else begin
               tx_div_d = tx_div_q + DIV_ONE;
            end
         end
         TX_DATA: begin
            if (tx_div_q == DIV_LAST) begin
               tx_div_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
               else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else begin
               tx_div_d = tx_div_q + DIV_ONE;
            end
         end
         TX_STOP: begin
            if (tx_div_q == DIV_LAST) begin
               tx_div_d = '0;
               if (!tbre_q) begin
                  tx_shift_d = thr_q;
                  tbre_d     = 1'b1;
                  tx_state_d = TX_START;
               end else begin
                  tsre_d     = 1'b1;
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_div_d = tx_div_q + DIV_ONE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      // A host write landing in the same cycle as a load wins, so its byte follows.
      if (wr_rise) begin
         thr_d  = wr_byte_q;
         tbre_d = 1'b0;
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_shift_d  = rx_shift_q;
      rx_div_d    = rx_div_q;
      rx_bit_d    = rx_bit_q;
      push_req    = 1'b0;
      frame_err_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s2_q) begin
               rx_div_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_div_q == HALF_LAST) begin
               rx_div_d   = '0;
               rx_bit_d   = 3'd0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_div_d = rx_div_q + DIV_ONE;
            end
         end
         RX_DATA: begin
            if (rx_div_q == DIV_LAST) begin
               rx_div_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_div_d = rx_div_q + DIV_ONE;
            end
         end
         RX_STOP: begin
            if (rx_div_q == DIV_LAST) begin
               rx_div_d    = '0;
               push_req    = rx_s2_q;
               frame_err_d = ~rx_s2_q;
               rx_state_d  = RX_IDLE;
            end else begin
               rx_div_d = rx_div_q + DIV_ONE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      rx_overrun_d = rx_overrun_q | (push_req & ~push);
      if (push) begin
         mem_d[wr_ptr_q] = rx_shift_q;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      data_ready_d = (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdn_q        <= 1'b1;
         wrn_q        <= 1'b1;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         wr_byte_q    <= '0;
         thr_q        <= '0;
         tbre_q       <= 1'b1;
         tsre_q       <= 1'b1;
         tx_state_q   <= TX_IDLE;
         tx_shift_q   <= '0;
         tx_div_q     <= '0;
         tx_bit_q     <= '0;
         rx_state_q   <= RX_IDLE;
         rx_shift_q   <= '0;
         rx_div_q     <= '0;
         rx_bit_q     <= '0;
         frame_err_q  <= 1'b0;
         rx_overrun_q <= 1'b0;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_ready_q <= 1'b0;
      end else begin
         rdn_q        <= rdn_d;
         wrn_q        <= wrn_d;
         rx_s1_q      <= rx_s1_d;
         rx_s2_q      <= rx_s2_d;
         wr_byte_q    <= wr_byte_d;
         thr_q        <= thr_d;
         tbre_q       <= tbre_d;
         tsre_q       <= tsre_d;
         tx_state_q   <= tx_state_d;
         tx_shift_q   <= tx_shift_d;
         tx_div_q     <= tx_div_d;
         tx_bit_q     <= tx_bit_d;
         rx_state_q   <= rx_state_d;
         rx_shift_q   <= rx_shift_d;
         rx_div_q     <= rx_div_d;
         rx_bit_q     <= rx_bit_d;
         frame_err_q  <= frame_err_d;
         rx_overrun_q <= rx_overrun_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         data_ready_q <= data_ready_d;
      end
   end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder: written bytes are checked bit by bit on
// txd, serial bytes driven on rxd are checked when the host reads them back.
module tb_uart_bus_responder;
   localparam int CLK_DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rxd = 1'b1;
   logic txd, rx_overrun, frame_err;

   uart_bus_responder_if bus_if ();

   uart_bus_responder #(.CLK_DIV(CLK_DIV), .FIFO_AW(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if),
      .rxd(rxd),
      .txd(txd),
      .rx_overrun(rx_overrun),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int fe_count = 0;
   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   logic tx_busy = 1'b0;
   logic tx_abort = 1'b0;
   logic bg_done = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic hostWrite(input logic [7:0] b, input int low_cycles);
      bus_if.data_in = b;
      bus_if.wrn = 1'b0;
      repeat (low_cycles) @(negedge clk);
      bus_if.wrn = 1'b1;
      tx_exp.push_back(b);
      @(negedge clk);
   endtask

   task automatic hostRead(input string tag);
      logic [7:0] want;
      bus_if.rdn = 1'b0;
      #1;
      want = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
      checkOutput({tag, "_oe"}, 32'(bus_if.data_oe), 1);
      checkOutput(tag, 32'(bus_if.data_out), 32'(want));
      @(negedge clk);
      bus_if.rdn = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_oe_off"}, 32'(bus_if.data_oe), 0);
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic expect_push);
      logic [9:0] frame;
      if (expect_push) rx_exp.push_back(b);
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = frame[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      rxd = 1'b1;
   endtask

   task automatic waitTxIdle(input int budget);
      int n;
      n = 0;
      while ((bus_if.tsre !== 1'b1 || tx_busy || tx_exp.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("tx_idle_in_time", 32'(n < budget), 1);
   endtask

   // Every cycle of a frame is compared, so bit length and order are both covered.
   initial begin
      logic [7:0] want;
      logic [9:0] frame;
      forever begin
         @(negedge clk);
         if (rst && txd === 1'b0) begin
            tx_busy = 1'b1;
            checkOutput("tx_frame_expected", 32'(tx_exp.size() != 0), 1);
            want = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'h00;
            frame = {1'b1, want, 1'b0};
            for (int i = 0; i < 10 * CLK_DIV; i++) begin
               if (i > 0) @(negedge clk);
               if (!tx_abort) checkOutput("txd_bit", 32'(txd), 32'(frame[i / CLK_DIV]));
            end
            tx_abort = 1'b0;
            tx_busy = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (frame_err === 1'b1) fe_count++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, %0d tests run", tests_run);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int fe_base;
      int n;
      bus_if.rdn = 1'b1;
      bus_if.wrn = 1'b1;
      bus_if.data_in = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("rst_txd", 32'(txd), 1);
      checkOutput("rst_tbre", 32'(bus_if.tbre), 1);
      checkOutput("rst_tsre", 32'(bus_if.tsre), 1);
      checkOutput("rst_data_ready", 32'(bus_if.data_ready), 0);
      checkOutput("rst_overrun", 32'(rx_overrun), 0);
      checkOutput("rst_frame_err", 32'(frame_err), 0);
      checkOutput("rst_data_out", 32'(bus_if.data_out), 0);
      checkOutput("rst_data_oe", 32'(bus_if.data_oe), 0);
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] single write 0xA5");
      hostWrite(8'hA5, 2);
      checkOutput("tbre_after_write", 32'(bus_if.tbre), 0);
      checkOutput("tsre_before_load", 32'(bus_if.tsre), 1);
      @(negedge clk);
      checkOutput("tbre_after_load", 32'(bus_if.tbre), 1);
      checkOutput("tsre_after_load", 32'(bus_if.tsre), 0);
      repeat (39) @(negedge clk);
      checkOutput("tsre_last_stop_cycle", 32'(bus_if.tsre), 0);
      @(negedge clk);
      checkOutput("tsre_frame_done", 32'(bus_if.tsre), 1);
      repeat (5) @(negedge clk);

      $display("[TB] back-to-back writes 0x12, 0x34");
      hostWrite(8'h12, 1);
      hostWrite(8'h34, 1);
      repeat (38) @(negedge clk);
      checkOutput("b2b_tbre_pending", 32'(bus_if.tbre), 0);
      checkOutput("b2b_stop_bit", 32'(txd), 1);
      @(negedge clk);
      checkOutput("b2b_no_gap", 32'(txd), 0);
      checkOutput("b2b_tbre_reload", 32'(bus_if.tbre), 1);
      checkOutput("b2b_tsre_busy", 32'(bus_if.tsre), 0);
      waitTxIdle(200);

      $display("[TB] receive 0x3C");
      applyStimulus(8'h3C, 1'b1, 1'b1);
      checkOutput("ready_before_push", 32'(bus_if.data_ready), 0);
      @(negedge clk);
      checkOutput("ready_after_push", 32'(bus_if.data_ready), 1);
      checkOutput("no_frame_err", 32'(frame_err), 0);
      hostRead("rx_3c");
      checkOutput("ready_after_pop", 32'(bus_if.data_ready), 0);

      $display("[TB] overrun with five bytes");
      for (int k = 1; k <= 5; k++) applyStimulus(8'(k), 1'b1, k <= 4);
      repeat (3) @(negedge clk);
      checkOutput("overrun_set", 32'(rx_overrun), 1);
      repeat (4) hostRead("rx_fifo");
      checkOutput("ready_drained", 32'(bus_if.data_ready), 0);
      hostRead("rx_empty");
      checkOutput("ready_empty_read", 32'(bus_if.data_ready), 0);
      checkOutput("overrun_sticky", 32'(rx_overrun), 1);

      $display("[TB] glitch and framing error");
      fe_base = fe_count;
      rxd = 1'b0;
      @(negedge clk);
      rxd = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("glitch_no_push", 32'(bus_if.data_ready), 0);
      checkOutput("glitch_no_fe", fe_count - fe_base, 0);
      applyStimulus(8'h5A, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(8'hC3, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("frame_err_pulse", 32'(frame_err), 1);
      @(negedge clk);
      checkOutput("frame_err_one_cycle", 32'(frame_err), 0);
      repeat (6) @(negedge clk);
      checkOutput("frame_err_count", fe_count - fe_base, 1);
      hostRead("rx_after_fe");
      checkOutput("ready_after_fe_read", 32'(bus_if.data_ready), 0);

      $display("[TB] reset mid-frame");
      applyStimulus(8'h77, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("ready_pre_reset", 32'(bus_if.data_ready), 1);
      hostWrite(8'h55, 1);
      fork
         begin
            applyStimulus(8'h99, 1'b1, 1'b0);
            bg_done = 1'b1;
         end
      join_none
      repeat (12) @(negedge clk);
      #2;
      tx_abort = tx_busy;
      tx_exp.delete();
      rx_exp.delete();
      rst = 1'b0;
      #1;
      checkOutput("async_rst_txd", 32'(txd), 1);
      checkOutput("async_rst_tbre", 32'(bus_if.tbre), 1);
      checkOutput("async_rst_tsre", 32'(bus_if.tsre), 1);
      checkOutput("async_rst_ready", 32'(bus_if.data_ready), 0);
      checkOutput("async_rst_overrun", 32'(rx_overrun), 0);
      n = 0;
      while (!bg_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rx_stimulus_done", 32'(bg_done), 1);
      @(negedge clk);
      rst = 1'b1;
      repeat (50) @(negedge clk);

      $display("[TB] traffic after reset");
      hostWrite(8'h66, 1);
      applyStimulus(8'h81, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("ready_post_reset", 32'(bus_if.data_ready), 1);
      hostRead("rx_post_reset");
      waitTxIdle(200);
      checkOutput("tx_leftover", tx_exp.size(), 0);
      checkOutput("rx_leftover", rx_exp.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
